// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity selectors, line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts 0..prescale-1 and pulses bit_done on the last cycle of each bit.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] count;

  assign bit_done = (count == (prescale - PRESCALE_WIDTH'(1)));

  // Free-running bit counter, held at zero while cleared and wrapped at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || bit_done) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. Each bit lasts `prescale` clocks.
// Optional feature macro: UART_TX_PARITY_EN (enables the parity bit).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t                 state, state_n;
  logic [DATA_WIDTH-1:0]     data_sr, data_sr_n, data_shift;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_eff;
  logic                      tx_n, busy_n;
  logic                      load;
  logic                      bit_done;
  logic                      timer_clear;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  logic par_bit_calc;

  assign par_bit_calc = (par_typ == PAR_ODD) ? ~^p_data : ^p_data;
`else
  logic unused_par;

  assign unused_par = par_en ^ par_typ;
`endif

  assign prescale_eff = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign data_shift   = data_sr >> 1;
  assign timer_clear  = (state == IDLE);

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .prescale (prescale_q),
    .bit_done (bit_done)
  );

  // State, index and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      tx_out <= LINE_IDLE;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      tx_out <= tx_n;
      busy   <= busy_n;
    end
  end

  // Frame configuration is captured once at acceptance; the shift register advances per data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr    <= '0;
      prescale_q <= PRESCALE_WIDTH'(1);
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else if (load) begin
      data_sr    <= p_data;
      prescale_q <= prescale_eff;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en;
      par_bit_q  <= par_bit_calc;
`endif
    end else begin
      data_sr    <= data_sr_n;
    end
  end

  // Next-state logic; line level for the upcoming cycle is decided here so tx_out stays registered.
  always_comb begin
    state_n   = state;
    data_sr_n = data_sr;
    idx_n     = idx;
    tx_n      = tx_out;
    busy_n    = busy;
    load      = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = LINE_IDLE;
        busy_n = 1'b0;
        if (data_valid) begin
          load    = 1'b1;
          state_n = START;
          tx_n    = START_BIT;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = data_sr[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = par_bit_q;
            end else begin
              state_n = STOP;
              tx_n    = LINE_IDLE;
            end
`else
            state_n = STOP;
            tx_n    = LINE_IDLE;
`endif
          end else begin
            idx_n     = idx + IDX_W'(1);
            data_sr_n = data_shift;
            tx_n      = data_shift[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
          tx_n    = LINE_IDLE;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_n = IDLE;
          tx_n    = LINE_IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = LINE_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame.
// Expected frames are written out by hand, transmit order from bit 0 upward.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_frame #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_output($sformatf("%s tx c%0d", tag, i), tx_out, 1'b1);
      check_output($sformatf("%s busy c%0d", tag, i), busy, 1'b0);
    end
  endtask

  // Called at a negedge with the DUT idle; the frame is accepted on the next posedge.
  // Every cycle of the frame is sampled, then one more cycle that must be idle.
  task automatic apply_stimulus(input string tag, input logic [7:0] d, input logic pe,
                                input logic pt, input logic [5:0] ps, input int p_eff,
                                input logic [10:0] exp_bits, input int nbits,
                                input bit hold_valid, input int pulse_at);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_valid) data_valid = 1'b0;
    p_data   = ~d;
    prescale = ps + 6'd5;
    for (int k = 0; k < nbits * p_eff; k++) begin
      @(negedge clk);
      check_output($sformatf("%s tx k%0d", tag, k), tx_out, exp_bits[k / p_eff]);
      check_output($sformatf("%s busy k%0d", tag, k), busy, 1'b1);
      if (k == pulse_at) begin
        data_valid = 1'b1;
        p_data     = 8'h3C;
        prescale   = 6'd3;
        par_en     = ~pe;
        par_typ    = ~pt;
      end else if (k == pulse_at + 1) begin
        data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_output($sformatf("%s end tx", tag), tx_out, 1'b1);
    check_output($sformatf("%s end busy", tag), busy, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd8;

    $display("[TB] reset state");
    #3;
    check_output("reset tx", tx_out, 1'b1);
    check_output("reset busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_idle("post reset", 3);

    $display("[TB] reset mid-frame");
    p_data     = 8'hA5;
    par_en     = 1'b0;
    prescale   = 6'd8;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (19) @(negedge clk);
    check_output("mid d1 tx", tx_out, 1'b0);
    check_output("mid d1 busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async rst tx", tx_out, 1'b1);
    check_output("async rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_idle("after mid rst", 8);

    $display("[TB] even parity 0xA5 prescale 8");
    apply_stimulus("A5 even", 8'hA5, 1'b1, 1'b0, 6'd8, 8,
                   PAR ? 11'b10101001010 : 11'b01101001010, PAR ? 11 : 10, 1'b0, -1);
    check_idle("A5 idle", 4);

    $display("[TB] odd parity 0x07 prescale 16");
    apply_stimulus("07 odd", 8'h07, 1'b1, 1'b1, 6'd16, 16,
                   PAR ? 11'b10000001110 : 11'b01000001110, PAR ? 11 : 10, 1'b0, -1);
    check_idle("07 odd idle", 4);

    $display("[TB] no parity 0x07 prescale 16");
    apply_stimulus("07 nopar", 8'h07, 1'b0, 1'b1, 6'd16, 16,
                   11'b01000001110, 10, 1'b0, -1);
    check_idle("07 nopar idle", 4);

    $display("[TB] request while busy is dropped");
    apply_stimulus("A5 ignore", 8'hA5, 1'b0, 1'b0, 6'd8, 8,
                   11'b01101001010, 10, 1'b0, 30);
    check_idle("no 3C", 20);

    $display("[TB] back-to-back 0x55 then 0xAA");
    apply_stimulus("55 b2b", 8'h55, 1'b0, 1'b0, 6'd8, 8,
                   11'b01010101010, 10, 1'b1, -1);
    apply_stimulus("AA b2b", 8'hAA, 1'b0, 1'b0, 6'd8, 8,
                   11'b01101010100, 10, 1'b0, -1);
    check_idle("b2b idle", 4);

    $display("[TB] prescale 0 and 1");
    apply_stimulus("81 ps0", 8'h81, 1'b0, 1'b0, 6'd0, 1,
                   11'b01100000010, 10, 1'b0, -1);
    check_idle("ps0 idle", 2);
    apply_stimulus("81 ps1", 8'h81, 1'b0, 1'b0, 6'd1, 1,
                   11'b01100000010, 10, 1'b0, -1);
    check_idle("ps1 idle", 2);
    apply_stimulus("81 ps1 paren", 8'h81, 1'b1, 1'b0, 6'd1, 1,
                   PAR ? 11'b10100000010 : 11'b01100000010, PAR ? 11 : 10, 1'b0, -1);
    check_idle("ps1 paren idle", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
